// File: rtl/ula_pkg.sv
// Shared types and widths for the ula datapath and its sequential issue stage.
package ula_pkg;

  localparam int unsigned ULA_W = 8;
  localparam int unsigned OP_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/ula.sv
// Combinational ALU: add/sub wrap modulo 2^W, carry and borrow discarded.
module ula
  import ula_pkg::*;
#(
  parameter int unsigned W = ULA_W
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  ula_op_e      OP,
  output logic [W-1:0] Result
);

  always_comb begin
    Result = '0;
    unique case (OP)
      OP_ADD: Result = A + B;
      OP_SUB: Result = A - B;
      OP_AND: Result = A & B;
      OP_OR:  Result = A | B;
    endcase
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential issue stage around ula: accept request, execute one cycle,
// hold the result until consumed. Accumulator allows chaining on the last result.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned W     = ULA_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic             in_use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e     state;
  seq_state_e     state_next;
  logic           load_ops;
  logic           capture;
  logic           complete;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  ula_op_e        op_sel;
  logic [W-1:0]   ula_res;

  ula #(.W(W)) u_ula (
    .A      (op_a),
    .B      (op_b),
    .OP     (op_sel),
    .Result (ula_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus one-cycle strobes for the datapath registers.
  always_comb begin
    state_next = state;
    load_ops   = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load_ops   = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= OP_ADD;
    end else if (load_ops) begin
      op_a   <= in_use_acc ? acc : in_a;
      op_b   <= in_b;
      op_sel <= ula_op_e'(in_op);
    end
  end

  // Result, flags and accumulator all update together at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_zero   <= 1'b1;
      out_neg    <= 1'b0;
      acc        <= '0;
    end else if (capture) begin
      out_result <= ula_res;
      out_zero   <= (ula_res == '0);
      out_neg    <= ula_res[W-1];
      acc        <= ula_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        op_count <= '0;
    else if (complete) op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: doc/ula_seq.md
# ula_seq

Sequential issue stage directly upstream of the combinational `ula`. Accepts operation requests over a valid/ready handshake and drives `ula` with registered operands. Captures the 8-bit result with status flags and presents it on a valid/ready output. Keeps an accumulator so chained operations can reuse the previous result as operand A.

## Interface
Parameters:
- `W`, 8, operand/result width; must match `ula`.
- `CNT_W`, 16, width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept a request.
- `in_a`  in  W  operand A; ignored when `in_use_acc`=1.
- `in_b`  in  W  operand B.
- `in_op`  in  2  operation: 00 add, 01 sub, 10 AND, 11 OR.
- `in_use_acc`  in  1  1 = use the accumulator as operand A.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  W  registered `ula` result.
- `out_zero`  out  1  `out_result` == 0.
- `out_neg`  out  1  `out_result[W-1]`.
- `acc`  out  W  accumulator value.
- `op_count`  out  CNT_W  completed operations; wraps modulo 2^CNT_W.

## Operation
- FSM has three states, encoded as IDLE, EXEC and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch operand A (either `in_a` or `acc`), `in_b` and `in_op` into operand registers, then go to EXEC.
- EXEC:
  - `in_ready`=0.
  - Registered operands drive `ula` for one full cycle.
  - At the end of the cycle, capture `ula` Result into `out_result`, compute flags from it, write `acc` with the same value, and go to DONE.
- DONE:
  - `out_valid`=1; `out_result` and flags are held stable.
  - On `out_ready`: increment `op_count` and go to IDLE.
  - Otherwise stay in DONE indefinitely; there is no timeout.
- Arithmetic is modulo 2^W. Add and sub wrap; carry and borrow are discarded, as in `ula`.
  - 8'd250 + 8'd10 = 8'd4.
  - 8'd5 − 8'd10 = 8'd251.
- `in_use_acc` samples `acc` as it is at the acceptance edge, i.e. the result of the previously captured operation.
- Reset, asynchronous and valid at any time including mid-operation:
  - State returns to IDLE; any in-flight request is dropped.
  - `in_ready`=1 once reset is released; `out_valid`=0.
  - `out_result`, `out_zero`, `out_neg`, `acc`, `op_count` and the operand registers all go to 0. Exception: `out_zero` resets to 1, consistent with `out_result`=0.
- `in_*` signals are ignored outside IDLE. The upstream must hold them until it sees `in_ready`.

## Timing
- Acceptance at edge t0 → EXEC during cycle t0..t1.
- Result captured at t1 → `out_valid`=1 from t1.
- Latency is 1 cycle from acceptance to `out_valid`.
- If `out_ready` is already high at t1, handshake completes at t2 and `in_ready` is 1 again from t2.
- Best-case throughput is one operation per 3 cycles. There is no overlap: `in_ready`=0 in EXEC and DONE.
- `op_count` updates at the edge that completes the output handshake.
- `acc` updates at the capture edge (t1), not at the handshake.
- All outputs are registered or decoded purely from the state register. There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared package `ula_pkg`:
  - `ula_op_e` enum (`OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_AND`=2'b10, `OP_OR`=2'b11).
  - `seq_state_e` enum (IDLE, EXEC, DONE).
  - Localparam `ULA_W`=8.
- One sub-module: the existing `ula`, instantiated as `u_ula`. Its `A`, `B` and `OP` inputs come from the operand registers; its `Result` goes to the capture logic.
- No other hierarchy.

## Test plan
- Reset mid-EXEC → next cycle: `in_ready`=1, `out_valid`=0, `acc`=0, `op_count`=0, `out_zero`=1.
- Request A=10, B=5, op 00 with `out_ready`=1 → `out_valid` one cycle after acceptance, `out_result`=15, `out_zero`=0, `out_neg`=0, `acc`=15, `op_count`=1.
- Chained requests:
  - A=10, B=5, op 01 → result 5.
  - Then `in_use_acc`=1, B=5, op 01 → result 0, `out_zero`=1.
  - Then `in_use_acc`=1, B=1, op 01 → result 255, `out_neg`=1.
- Back-pressure:
  - A=8'b11001100, B=8'b10101010, op 10, with `out_ready`=0 for 5 cycles → `out_valid` held, result 8'b10001000 stable, `in_ready`=0, new `in_valid` ignored.
  - Then op 11 on the same operands → 8'b11101110.
- Wrap: A=250, B=10, op 00 → 4. Separately, preload `op_count` to 16'hFFFF via 65535 operations (or force), then one more operation → `op_count`=0.
- Back-to-back `in_valid` held high with `out_ready`=1 → exactly one acceptance per 3 cycles; `op_count` matches the number of completed handshakes.
